// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

    // Scancode prefixes that modify the following key byte
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // Frame deserialiser states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    // One decoded key event
    typedef struct packed {
        logic       ext;
        logic [7:0] code;
        logic       rel;
    } ps2_evt_raw_unused_t;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } ps2_evt_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// Generic first-word-fall-through FIFO holding decoded key events.
// Latency: a push is visible at the head one cycle later (no empty bypass).
// Backpressure: pops gated by !empty; a push while full is dropped unless a pop happens the same cycle.
//
// Ports: clock/resetn; push_vld/push_dat write side; pop_rdy read strobe;
//        head_dat current head; count, full, empty occupancy status.
module ps2_event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       push_vld,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop_rdy,
    output logic [WIDTH-1:0]           head_dat,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign head_dat = mem[rd_ptr];

    assign do_pop  = pop_rdy && !empty;
    // A full FIFO still accepts when the head leaves in the same cycle
    assign do_push = push_vld && (!full || do_pop);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: pin filtering, 11-bit deframing, E0/F0 folding into buffered key events.
// Latency: raw_strobe one cycle after the stop-bit fall; event valid two cycles after it (empty FIFO).
// Backpressure: evt_valid/evt_ready pop; events arriving to a full FIFO are dropped and flag overflow.
//
// Ports: clock/resetn; ps2_clk/ps2_dat raw pins; evt_* FIFO head and handshake; fifo_count;
//        busy, raw_strobe/raw_byte, parity_err, frame_err debug strobes; overflow sticky with ovf_clear.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                            clock,
    input  logic                            resetn,
    input  logic                            ps2_clk,
    input  logic                            ps2_dat,
    output logic                            evt_valid,
    input  logic                            evt_ready,
    output logic [7:0]                      evt_code,
    output logic                            evt_release,
    output logic                            evt_extended,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            busy,
    output logic                            raw_strobe,
    output logic [7:0]                      raw_byte,
    output logic                            parity_err,
    output logic                            frame_err,
    output logic                            overflow,
    input  logic                            ovf_clear
);

    localparam logic [7:0] FCNT_LAST = 8'(FILTER_LEN - 1);
    localparam int         TCW       = $clog2(TIMEOUT_CYCLES + 1);
    // tcnt reads 0 in the cycle after a fall, so it lags elapsed cycles by one; firing at
    // TIMEOUT_CYCLES-2 lands the registered frame_err exactly TIMEOUT_CYCLES after the fall cycle.
    localparam logic [TCW-1:0] TCNT_HIT = TCW'(TIMEOUT_CYCLES - 2);
    localparam logic [TCW-1:0] TCNT_ONE = TCW'(1);

    // ---------------- input conditioning: index 0 = clk line, 1 = dat line
    logic [1:0] sync_a;
    logic [1:0] sync_b;
    logic [1:0] filt;
    logic [7:0] fcnt [2];
    logic       filt_clk_q;
    logic       fall;
    logic       dat;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_a     <= 2'b11;
            sync_b     <= 2'b11;
            filt       <= 2'b11;
            filt_clk_q <= 1'b1;
            fcnt[0]    <= '0;
            fcnt[1]    <= '0;
        end else begin
            sync_a     <= {ps2_dat, ps2_clk};
            sync_b     <= sync_a;
            filt_clk_q <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] != filt[i]) begin
                    if (fcnt[i] == FCNT_LAST) begin
                        filt[i] <= sync_b[i];
                        fcnt[i] <= '0;
                    end else begin
                        fcnt[i] <= fcnt[i] + 8'd1;
                    end
                end else begin
                    fcnt[i] <= '0;
                end
            end
        end
    end

    assign fall = filt_clk_q && !filt[0];
    assign dat  = filt[1];

    // ---------------- frame FSM
    frame_state_t   state_q, state_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     sh_q, sh_d;
    logic           par_q, par_d;
    logic [TCW-1:0] tcnt_q, tcnt_d;
    logic           good_d, perr_d, ferr_d;
    logic           timeout_hit;

    assign timeout_hit = (state_q != IDLE) && !fall && (tcnt_q == TCNT_HIT);
    assign busy        = (state_q != IDLE);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            bit_q      <= '0;
            sh_q       <= '0;
            par_q      <= 1'b0;
            tcnt_q     <= '0;
            raw_strobe <= 1'b0;
            raw_byte   <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            par_q      <= par_d;
            tcnt_q     <= tcnt_d;
            raw_strobe <= good_d;
            parity_err <= perr_d;
            frame_err  <= ferr_d;
            if (good_d) begin
                raw_byte <= sh_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        tcnt_d  = tcnt_q;
        good_d  = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;

        if (fall) begin
            tcnt_d = '0;
        end else if (state_q != IDLE) begin
            tcnt_d = tcnt_q + TCNT_ONE;
        end

        case (state_q)
            IDLE: begin
                // A fall with dat high is not a start bit; ignore it silently
                if (fall && !dat) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    sh_d  = {dat, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    par_d   = dat;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    // Parity failure takes precedence; the stop bit is then irrelevant
                    if (!(^{sh_q, par_q})) begin
                        perr_d = 1'b1;
                    end else if (!dat) begin
                        ferr_d = 1'b1;
                    end else begin
                        good_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout_hit) begin
            state_d = IDLE;
            bit_d   = '0;
            ferr_d  = 1'b1;
        end
    end

    // ---------------- prefix folding and event buffering
    logic     ext_q, rel_q;
    logic     push_vld;
    ps2_evt_t push_evt;
    ps2_evt_t head_evt;
    logic     fifo_full;
    logic     fifo_empty;
    logic     pop;

    assign push_vld = raw_strobe && (raw_byte != PS2_EXT) && (raw_byte != PS2_BRK);
    assign push_evt = '{ext: ext_q, rel: rel_q, code: raw_byte};
    assign pop      = evt_valid && evt_ready;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ext_q    <= 1'b0;
            rel_q    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (parity_err || frame_err) begin
                ext_q <= 1'b0;
                rel_q <= 1'b0;
            end else if (raw_strobe) begin
                if (raw_byte == PS2_EXT) begin
                    ext_q <= 1'b1;
                end else if (raw_byte == PS2_BRK) begin
                    rel_q <= 1'b1;
                end else begin
                    ext_q <= 1'b0;
                    rel_q <= 1'b0;
                end
            end
            if (ovf_clear) begin
                overflow <= 1'b0;
            end else if (push_vld && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    ps2_event_fifo #(
        .WIDTH ($bits(ps2_evt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .resetn   (resetn),
        .push_vld (push_vld),
        .push_dat (push_evt),
        .pop_rdy  (evt_ready),
        .head_dat (head_evt),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign evt_valid    = !fifo_empty;
    assign evt_code     = head_evt.code;
    assign evt_release  = head_evt.rel;
    assign evt_extended = head_evt.ext;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
module tb_ps2_scancode_rx;

    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 300;
    localparam int FIFO_DEPTH     = 8;
    // Pin drop -> 2 sync flops -> FILTER_LEN filter samples gives the fall cycle;
    // frame_err then appears TIMEOUT_CYCLES cycles after that fall cycle.
    localparam int TMO_EDGE       = 2 + FILTER_LEN + TIMEOUT_CYCLES;

    logic       clock = 1'b0;
    logic       resetn;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_release;
    logic       evt_extended;
    logic [3:0] fifo_count;
    logic       busy;
    logic       raw_strobe;
    logic [7:0] raw_byte;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;
    logic       ovf_clear;

    int checks = 0;
    int errors = 0;

    // Monotonic pulse counters; the stimulus takes deltas
    int n_strobe = 0;
    int n_perr   = 0;
    int n_ferr   = 0;

    ps2_scancode_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .FIFO_DEPTH     (FIFO_DEPTH)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .ps2_clk      (ps2_clk),
        .ps2_dat      (ps2_dat),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_code     (evt_code),
        .evt_release  (evt_release),
        .evt_extended (evt_extended),
        .fifo_count   (fifo_count),
        .busy         (busy),
        .raw_strobe   (raw_strobe),
        .raw_byte     (raw_byte),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .overflow     (overflow),
        .ovf_clear    (ovf_clear)
    );

    always #10 clock = ~clock;

    always @(negedge clock) begin
        if (raw_strobe === 1'b1) n_strobe++;
        if (parity_err === 1'b1) n_perr++;
        if (frame_err === 1'b1)  n_ferr++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        ps2_dat = b;
        if (glitch) begin
            cyc(2);
            ps2_clk = 1'b0;
            cyc(3);
            ps2_clk = 1'b1;
            cyc(3);
        end else begin
            cyc(8);
        end
        ps2_clk = 1'b0;
        cyc(10);
        ps2_clk = 1'b1;
        cyc(4);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(b[i], glitch && (i == 3));
        end
        send_bit((~^b) ^ bad_par, 1'b0);
        send_bit(1'b1, 1'b0);
        ps2_dat = 1'b1;
        cyc(4);
    endtask

    task automatic pop_one();
        evt_ready = 1'b1;
        cyc(1);
        evt_ready = 1'b0;
    endtask

    initial begin
        int s0, p0, f0;
        int found_k;
        logic [7:0] b;

        resetn    = 1'b0;
        ps2_clk   = 1'b1;
        ps2_dat   = 1'b1;
        evt_ready = 1'b0;
        ovf_clear = 1'b0;
        cyc(3);
        check("rst_evt_valid",  evt_valid, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_busy",       busy, 0);
        check("rst_raw_byte",   raw_byte, 0);
        check("rst_raw_strobe", raw_strobe, 0);
        check("rst_errs",       {parity_err, frame_err, overflow}, 0);
        check("rst_evt_head",   {evt_code, evt_release, evt_extended}, 0);
        resetn = 1'b1;
        cyc(5);

        // 1: single press with a short clock glitch mid-frame
        s0 = n_strobe; p0 = n_perr; f0 = n_ferr;
        send_frame(8'h1C, 1'b0, 1'b1);
        check("t1_strobes",  n_strobe - s0, 1);
        check("t1_raw_byte", raw_byte, 8'h1C);
        check("t1_busy",     busy, 0);
        check("t1_no_errs",  (n_perr - p0) + (n_ferr - f0), 0);
        check("t1_valid",    evt_valid, 1);
        check("t1_count",    fifo_count, 1);
        check("t1_event",    {evt_code, evt_release, evt_extended}, {8'h1C, 2'b00});
        pop_one();
        check("t1_empty",    fifo_count, 0);

        // 2: break and extended-break prefixes fold into two events
        s0 = n_strobe;
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        check("t2_strobes", n_strobe - s0, 5);
        check("t2_count",   fifo_count, 2);
        check("t2_ev0",     {evt_code, evt_release, evt_extended}, {8'h1C, 2'b10});
        pop_one();
        check("t2_ev1",     {evt_code, evt_release, evt_extended}, {8'h75, 2'b11});
        pop_one();
        check("t2_empty",   evt_valid, 0);

        // 3: parity error drops the byte and any pending prefix
        s0 = n_strobe; p0 = n_perr;
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b1, 1'b0);
        check("t3_perr",    n_perr - p0, 1);
        check("t3_strobes", n_strobe - s0, 1);
        check("t3_count",   fifo_count, 0);
        send_frame(8'h1C, 1'b0, 1'b0);
        check("t3_press",   {evt_valid, evt_code, evt_release, evt_extended}, {1'b1, 8'h1C, 2'b00});
        pop_one();

        // 4: stalled frame after start + 5 data bits times out
        f0 = n_ferr;
        b  = 8'h29;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send_bit(b[i], 1'b0);
        end
        ps2_dat = b[4];
        cyc(8);
        ps2_clk = 1'b0;
        found_k = -1;
        for (int k = 1; k <= TMO_EDGE + 50; k++) begin
            @(negedge clock);
            if (k == 10) ps2_clk = 1'b1;
            if (k == 20) check("t4_busy_mid", busy, 1);
            if (frame_err === 1'b1 && found_k < 0) found_k = k;
        end
        check("t4_tmo_edge", found_k, TMO_EDGE);
        check("t4_ferr_cnt", n_ferr - f0, 1);
        check("t4_busy",     busy, 0);
        ps2_dat = 1'b1;
        cyc(4);
        send_frame(8'h29, 1'b0, 1'b0);
        check("t4_event",    {evt_valid, evt_code, evt_release, evt_extended}, {1'b1, 8'h29, 2'b00});
        pop_one();

        // 5: overflow with consumer stalled
        for (int i = 0; i < 9; i++) begin
            b = 8'h15 + 8'(i);
            send_frame(b, 1'b0, 1'b0);
        end
        check("t5_count",    fifo_count, 8);
        check("t5_overflow", overflow, 1);
        for (int i = 0; i < 8; i++) begin
            check("t5_pop_code", {evt_valid, evt_code}, {1'b1, 8'h15 + 8'(i)});
            pop_one();
        end
        check("t5_drained",  evt_valid, 0);
        check("t5_ovf_held", overflow, 1);
        ovf_clear = 1'b1;
        cyc(1);
        ovf_clear = 1'b0;
        check("t5_ovf_clr",  overflow, 0);

        // 6: reset mid-frame then clean decode
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        ps2_dat = 1'b1;
        ps2_clk = 1'b0;
        cyc(8);
        resetn = 1'b0;
        cyc(2);
        check("t6_rst_busy",  busy, 0);
        check("t6_rst_raw",   raw_byte, 0);
        check("t6_rst_valid", {evt_valid, fifo_count}, 0);
        check("t6_rst_flags", {raw_strobe, parity_err, frame_err, overflow}, 0);
        ps2_clk = 1'b1;
        cyc(2);
        resetn = 1'b1;
        cyc(10);
        s0 = n_strobe; p0 = n_perr; f0 = n_ferr;
        send_frame(8'h1C, 1'b0, 1'b0);
        check("t6_strobe",    n_strobe - s0, 1);
        check("t6_no_errs",   (n_perr - p0) + (n_ferr - f0), 0);
        check("t6_event",     {evt_valid, evt_code, evt_release, evt_extended}, {1'b1, 8'h1C, 2'b00});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
Parametrised PS/2 keyboard receiver. It is the successor to the single-byte keyboard_PS2 receiver.
- Filters and synchronises the ps2_clk/ps2_dat lines, then deframes 11-bit frames with odd-parity and stop-bit checking.
- Recovers hung frames by timeout.
- Folds E0 (extended) and F0 (break) prefixes into key events and buffers them in a FIFO with a valid/ready pop interface.
- Sits between the PS/2 pins and game control logic; raw-byte and status strobes remain available for LED debug.

Parameters:
FILTER_LEN, 8, consecutive equal samples needed before a filtered line changes level (range 2..255).
TIMEOUT_CYCLES, 100000, clock cycles without a falling ps2_clk edge before an in-progress frame aborts (2 ms at 50 MHz).
FIFO_DEPTH, 8, event FIFO entries; power of two, 2..64.

Ports:
clock  in  1  system clock, 50 MHz.
resetn  in  1  asynchronous active-low reset.
ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
ps2_dat  in  1  raw PS/2 data pin, asynchronous.
evt_valid  out  1  FIFO head holds an event.
evt_ready  in  1  consumer accepts the head; a pop occurs when evt_valid && evt_ready.
evt_code  out  8  scancode at the FIFO head.
evt_release  out  1  head event is a key release (F0 seen).
evt_extended  out  1  head event is an extended key (E0 seen).
fifo_count  out  $clog2(FIFO_DEPTH+1)  number of stored events.
busy  out  1  high while a frame is being received.
raw_strobe  out  1  one-cycle pulse for each good byte.
raw_byte  out  8  last good byte; held until the next good byte.
parity_err  out  1  one-cycle pulse when a frame fails parity.
frame_err  out  1  one-cycle pulse on a bad stop bit or a timeout.
overflow  out  1  sticky: an event was dropped because the FIFO was full.
ovf_clear  in  1  synchronous clear of overflow.

Behaviour:
Reset:
- All outputs 0 and raw_byte = 0.
- Filtered lines and synchroniser flops = 1, since both lines idle high.
- FSM in IDLE, prefix flags cleared, FIFO empty.

Input conditioning:
- Each pin passes through a 2-FF synchroniser, then a filter counter.
- The filtered level flips only after FILTER_LEN consecutive samples that differ from it. Shorter glitches are ignored.
- fall = filtered ps2_clk was 1 and is now 0. Data is sampled from filtered ps2_dat in the fall cycle.

Frame FSM, states IDLE, DATA, PARITY, STOP:
- IDLE: on fall with dat=0, go to DATA and assert busy. On fall with dat=1 (bad start), stay in IDLE with no error.
- DATA: shift in 8 bits LSB first on each fall, then go to PARITY.
- PARITY: on fall, capture the parity bit and go to STOP.
- STOP, on fall:
  - Parity good (data ones + parity bit is odd) and dat=1: byte is good.
  - Parity bad: parity_err pulses; the stop bit is not judged.
  - Parity good but dat=0: frame_err pulses.
  - In every case, return to IDLE and deassert busy the same cycle.
- Timeout: a counter resets on every fall and runs while the FSM is not IDLE. Reaching TIMEOUT_CYCLES causes a frame_err pulse, return to IDLE, busy low and prefix flags cleared. The bit counter is cleared.
- Any error discards the byte and clears the prefix flags.

Good byte handling:
- raw_strobe and raw_byte update on the cycle after the stop fall.
- Decoder on that same cycle:
  - 0xE0 sets ext.
  - 0xF0 sets rel.
  - Any other byte (including 0xE1) emits the event {code, rel, ext} and clears both flags.
- An emitted event is written to the FIFO that cycle. evt_valid rises the next cycle if the FIFO was empty, i.e. 2 cycles after the stop fall.

FIFO:
- First-word-fall-through; head outputs are registered and stable while evt_valid && !evt_ready.
- Push when full without a simultaneous pop: event dropped and overflow set.
- Push and pop in the same cycle when full: both succeed and the count is unchanged.
- Push and pop in the same cycle when empty: no bypass; the event appears the next cycle.
- ovf_clear takes priority over a simultaneous set.
- evt_* outputs are don't-care while evt_valid = 0 and are driven 0 at reset.

Decomposition:
Package ps2_pkg holds:
- Constants PS2_EXT = 8'hE0, PS2_BRK = 8'hF0.
- The frame-state enum.
- The 10-bit event struct {ext, rel, code[7:0]}.

One sub-module, ps2_event_fifo: parametrised depth, FWFT, count and full/empty flags, instantiated once.

Test Plan:
1. Frame 0x1C with correct parity, plus a 3-cycle glitch on ps2_clk mid-frame → glitch ignored; raw_strobe with raw_byte=0x1C; one event code=0x1C, rel=0, ext=0; busy low after the stop bit.
2. Bytes F0,1C then E0,F0,75 → exactly two events: {1C, rel=1, ext=0} and {75, rel=1, ext=1}; fifo_count=2.
3. 0x1C with the parity bit flipped → parity_err pulse, no raw_strobe, no event; prefix flags cleared. A following good 0x1C gives a press event.
4. Start bit plus 5 data bits, then silence → frame_err pulse exactly TIMEOUT_CYCLES after the last fall; busy low. The next full 0x29 frame gives event 0x29.
5. Hold evt_ready=0 and send 9 press codes 0x15..0x1D → fifo_count=8, overflow=1. Popping yields 0x15..0x1C in order. ovf_clear drops overflow to 0.
6. Assert resetn low mid-frame (after 4 bits), release, then send 0x1C → all outputs 0 during reset; clean decode of 0x1C afterwards with no error pulses.
